// File: rtl/udp_receive_slot_scheduler_if.sv
// Handshake bundle between the UDP/IPv4 header parser, the per-slot receive FIFOs,
// the downstream sink and udp_receive_slot_scheduler.
interface udp_receive_slot_scheduler_if #(
  parameter int SLOT_COUNT       = 4,
  parameter int SLOT_INDEX_WIDTH = $clog2(SLOT_COUNT)
);
  logic                        packet_start;
  logic                        data_enable;
  logic                        good_packet;
  logic                        bad_packet;
  logic [SLOT_COUNT-1:0]       slot_ready;
  logic [SLOT_COUNT-1:0]       slot_data_ready;
  logic                        sink_ready;
  logic [SLOT_COUNT-1:0]       slot_data_enable;
  logic [SLOT_COUNT-1:0]       slot_good_packet;
  logic [SLOT_COUNT-1:0]       slot_bad_packet;
  logic [SLOT_COUNT-1:0]       slot_push_data_enable;
  logic                        drain_active;
  logic [SLOT_INDEX_WIDTH-1:0] drain_slot;
  logic [15:0]                 drop_count;

  modport master (
    output packet_start, data_enable, good_packet, bad_packet,
    output slot_ready, slot_data_ready, sink_ready,
    input  slot_data_enable, slot_good_packet, slot_bad_packet,
    input  slot_push_data_enable, drain_active, drain_slot, drop_count
  );

  modport slave (
    input  packet_start, data_enable, good_packet, bad_packet,
    input  slot_ready, slot_data_ready, sink_ready,
    output slot_data_enable, slot_good_packet, slot_bad_packet,
    output slot_push_data_enable, drain_active, drain_slot, drop_count
  );
endinterface

// File: rtl/udp_receive_slot_scheduler.sv
// Allocates parsed UDP packets to receive slots and round-robin drains completed slots.
// Optional drop counter: define UDP_RECEIVE_SLOT_SCHEDULER_DROP_COUNTER_EN.
module udp_receive_slot_scheduler #(
  parameter int SLOT_COUNT       = 4,
  parameter int SLOT_INDEX_WIDTH = $clog2(SLOT_COUNT)
) (
  input logic                         clock,
  input logic                         reset,
  udp_receive_slot_scheduler_if.slave bus
);

  typedef enum logic [1:0] {W_IDLE, W_FILL, W_DISCARD} w_state_t;
  typedef enum logic       {R_IDLE, R_DRAIN}           r_state_t;

  w_state_t                    r_w_state, w_w_state_nxt;
  r_state_t                    r_r_state, w_r_state_nxt;
  logic [SLOT_INDEX_WIDTH-1:0] r_fill_slot, w_fill_slot_nxt;
  logic [SLOT_INDEX_WIDTH-1:0] r_drain_slot, w_drain_slot_nxt;
  logic [SLOT_INDEX_WIDTH-1:0] r_rr_pointer, w_rr_pointer_nxt;
  logic [SLOT_COUNT-1:0]       w_cool_busy;
  logic [SLOT_COUNT-1:0]       w_exclude;
  logic [SLOT_COUNT-1:0]       w_avail;
  logic [SLOT_INDEX_WIDTH:0]   w_alloc;
  logic [SLOT_INDEX_WIDTH:0]   w_grant;
  logic [SLOT_COUNT-1:0]       w_de, w_good, w_bad, w_push, w_verdict;
  logic                        w_drop_inc;

  function automatic logic [SLOT_COUNT-1:0] onehot(input logic [SLOT_INDEX_WIDTH-1:0] idx);
    return SLOT_COUNT'(1) << idx;
  endfunction

  // Returns {found, index} of the lowest set request bit.
  function automatic logic [SLOT_INDEX_WIDTH:0] lowest_set(input logic [SLOT_COUNT-1:0] req);
    logic [SLOT_INDEX_WIDTH:0] res;
    res = '0;
    for (int i = SLOT_COUNT - 1; i >= 0; i--)
      if (req[i]) res = {1'b1, SLOT_INDEX_WIDTH'(i)};
    return res;
  endfunction

  // Returns {found, index} of the first set request bit at or after ptr, wrapping.
  function automatic logic [SLOT_INDEX_WIDTH:0] rr_search(input logic [SLOT_COUNT-1:0] req,
                                                           input logic [SLOT_INDEX_WIDTH-1:0] ptr);
    logic [SLOT_INDEX_WIDTH:0] res;
    int                        idx;
    res = '0;
    for (int i = SLOT_COUNT - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % SLOT_COUNT;
      if (req[SLOT_INDEX_WIDTH'(idx)]) res = {1'b1, SLOT_INDEX_WIDTH'(idx)};
    end
    return res;
  endfunction

  assign w_grant = rr_search(bus.slot_data_ready, r_rr_pointer);

  // A slot held by the sink, or being granted this very cycle, must not be refilled.
  always_comb begin
    w_exclude = '0;
    if (r_r_state == R_DRAIN)
      w_exclude = onehot(r_drain_slot);
    else if (w_grant[SLOT_INDEX_WIDTH])
      w_exclude = onehot(w_grant[SLOT_INDEX_WIDTH-1:0]);
  end

  assign w_avail = bus.slot_ready & ~w_cool_busy & ~w_exclude;
  assign w_alloc = lowest_set(w_avail);

  always_comb begin
    w_w_state_nxt   = r_w_state;
    w_fill_slot_nxt = r_fill_slot;
    w_de            = '0;
    w_good          = '0;
    w_bad           = '0;
    w_drop_inc      = 1'b0;
    case (r_w_state)
      W_IDLE: begin
        if (bus.packet_start) begin
          if (w_alloc[SLOT_INDEX_WIDTH]) begin
            w_fill_slot_nxt = w_alloc[SLOT_INDEX_WIDTH-1:0];
            w_w_state_nxt   = W_FILL;
            w_de            = onehot(w_alloc[SLOT_INDEX_WIDTH-1:0]) & {SLOT_COUNT{bus.data_enable}};
          end else begin
            w_w_state_nxt = W_DISCARD;
            w_drop_inc    = 1'b1;
          end
        end
      end
      W_FILL: begin
        if (bus.packet_start) begin
          // A new packet before a verdict: abort the slot and drop the newcomer.
          w_bad         = onehot(r_fill_slot);
          w_w_state_nxt = W_DISCARD;
          w_drop_inc    = 1'b1;
        end else begin
          w_de = onehot(r_fill_slot) & {SLOT_COUNT{bus.data_enable}};
          if (bus.bad_packet) begin
            w_bad         = onehot(r_fill_slot);
            w_w_state_nxt = W_IDLE;
          end else if (bus.good_packet) begin
            w_good        = onehot(r_fill_slot);
            w_w_state_nxt = W_IDLE;
          end
        end
      end
      W_DISCARD: begin
        if (bus.good_packet || bus.bad_packet) w_w_state_nxt = W_IDLE;
      end
      default: w_w_state_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    w_r_state_nxt    = r_r_state;
    w_drain_slot_nxt = r_drain_slot;
    w_rr_pointer_nxt = r_rr_pointer;
    w_push           = '0;
    case (r_r_state)
      R_IDLE: begin
        if (w_grant[SLOT_INDEX_WIDTH]) begin
          w_r_state_nxt    = R_DRAIN;
          w_drain_slot_nxt = w_grant[SLOT_INDEX_WIDTH-1:0];
        end
      end
      R_DRAIN: begin
        w_push = onehot(r_drain_slot) & {SLOT_COUNT{bus.sink_ready}};
        if (!bus.slot_data_ready[r_drain_slot]) begin
          w_r_state_nxt    = R_IDLE;
          w_rr_pointer_nxt = (r_drain_slot == SLOT_INDEX_WIDTH'(SLOT_COUNT - 1))
                             ? '0 : r_drain_slot + SLOT_INDEX_WIDTH'(1);
        end
      end
      default: w_r_state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_w_state    <= W_IDLE;
      r_r_state    <= R_IDLE;
      r_fill_slot  <= '0;
      r_drain_slot <= '0;
      r_rr_pointer <= '0;
    end else begin
      r_w_state    <= w_w_state_nxt;
      r_r_state    <= w_r_state_nxt;
      r_fill_slot  <= w_fill_slot_nxt;
      r_drain_slot <= w_drain_slot_nxt;
      r_rr_pointer <= w_rr_pointer_nxt;
    end
  end

  assign w_verdict = w_good | w_bad;

  // Cooldown masks the slot's registered ready lag for two cycles after a verdict.
  for (genvar g = 0; g < SLOT_COUNT; g++) begin : g_cool
    logic [1:0] r_cooldown;
    always_ff @(posedge clock or posedge reset) begin
      if (reset)                  r_cooldown <= '0;
      else if (w_verdict[g])      r_cooldown <= 2'd2;
      else if (r_cooldown != '0)  r_cooldown <= r_cooldown - 2'd1;
    end
    assign w_cool_busy[g] = (r_cooldown != '0);
  end

`ifdef UDP_RECEIVE_SLOT_SCHEDULER_DROP_COUNTER_EN
  logic [15:0] r_drop_count;
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                      r_drop_count <= '0;
    else if (w_drop_inc && r_drop_count != 16'hFFFF) r_drop_count <= r_drop_count + 16'd1;
  end
  assign bus.drop_count = r_drop_count;
`else
  logic w_unused_drop_inc;
  assign w_unused_drop_inc = w_drop_inc;
  assign bus.drop_count    = '0;
`endif

  assign bus.slot_data_enable      = w_de;
  assign bus.slot_good_packet      = w_good;
  assign bus.slot_bad_packet       = w_bad;
  assign bus.slot_push_data_enable = w_push;
  assign bus.drain_active          = (r_r_state == R_DRAIN);
  assign bus.drain_slot            = r_drain_slot;

endmodule
